// File: rtl/fetch_stage.sv
// RV32I fetch stage: fetch PC, imem requests, {pc, instr} buffer toward IF/ID; FETCH_MISALIGN_TRAP_EN adds misaligned-redirect halt.
// Latency: request in cycle 0, push end of cycle 1, VALID_D in cycle 2; redirect target valid at t+3 (t+4 when draining).
// Backpressure: READY_D low holds the head; requests stop once buffered plus in-flight entries reach DEPTH.

module fetch_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 2
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     clr,
   input  logic                     push,
   input  logic [W-1:0]             push_dat,
   input  logic                     pop,
   output logic [W-1:0]             head_dat,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   // Entries are cleared on reset so the head reads zero before the first push.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   assign head_dat = mem[rd_ptr];
endmodule

module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        CLK,
   input  logic        RST,
   output logic        IMEM_REQ,
   output logic [31:0] IMEM_ADDR,
   input  logic [31:0] IMEM_RDATA,
   input  logic        REDIRECT,
   input  logic [31:0] REDIRECT_PC,
   output logic        VALID_D,
   input  logic        READY_D,
   output logic [31:0] INSTR_D,
   output logic [31:0] PC_D,
   output logic [31:0] PCPLUS4_D
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic        MISALIGN_F
`endif
);
   localparam int            CW      = $clog2(DEPTH) + 1;
   localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

`ifdef FETCH_MISALIGN_TRAP_EN
   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT} state_t;
`else
   typedef enum logic [1:0] {S_RUN, S_DRAIN} state_t;
`endif

   state_t        state, state_nxt;
   logic [31:0]   fetch_pc, fetch_pc_nxt;
   logic          inflight, inflight_nxt;
   logic [31:0]   inflight_pc;
   logic          misalign, misalign_nxt;
   logic [CW-1:0] count;
   logic [CW:0]   occ;
   logic          pop;
   logic          push;
   logic [63:0]   head_dat;

   assign pop      = VALID_D & READY_D;
   assign occ      = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
   // Gated by RST so nothing is requested while reset is held.
   assign IMEM_REQ  = !RST && (state == S_RUN) && (occ < DEPTH_W);
   assign IMEM_ADDR = fetch_pc;
   assign push      = inflight & ~REDIRECT;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= S_RUN;
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         misalign    <= 1'b0;
      end else begin
         state       <= state_nxt;
         fetch_pc    <= fetch_pc_nxt;
         inflight    <= inflight_nxt;
         inflight_pc <= fetch_pc;
         misalign    <= misalign_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      inflight_nxt = IMEM_REQ;
      misalign_nxt = misalign;
      if (IMEM_REQ) fetch_pc_nxt = fetch_pc + 32'd4;
      if (state == S_DRAIN) state_nxt = S_RUN;
      // A request issued alongside a redirect is cancelled; its response slot is drained.
      if (REDIRECT) begin
         fetch_pc_nxt = REDIRECT_PC & 32'hFFFF_FFFC;
         inflight_nxt = 1'b0;
         state_nxt    = IMEM_REQ ? S_DRAIN : S_RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
         misalign_nxt = |REDIRECT_PC[1:0];
         if (misalign_nxt) state_nxt = S_HALT;
`endif
      end
   end

   fetch_fifo #(.W(64), .DEPTH(DEPTH)) u_buf (
      .CLK      (CLK),
      .RST      (RST),
      .clr      (REDIRECT),
      .push     (push),
      .push_dat ({inflight_pc, IMEM_RDATA}),
      .pop      (pop),
      .head_dat (head_dat),
      .count    (count)
   );

   assign VALID_D   = (count != '0);
   assign PC_D      = head_dat[63:32];
   assign INSTR_D   = head_dat[31:0];
   assign PCPLUS4_D = PC_D + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign MISALIGN_F = misalign;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming, backpressure, redirects, PC wrap, mid-stream reset.
// Memory returns addr ^ 0xAAAA one cycle after each request.

module tb_fetch_stage;
   logic        CLK = 1'b0;
   logic        RST;
   logic        IMEM_REQ;
   logic [31:0] IMEM_ADDR;
   logic [31:0] IMEM_RDATA = 32'h0;
   logic        REDIRECT;
   logic [31:0] REDIRECT_PC;
   logic        VALID_D;
   logic        READY_D;
   logic [31:0] INSTR_D;
   logic [31:0] PC_D;
   logic [31:0] PCPLUS4_D;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        MISALIGN_F;
`endif

   int checks   = 0;
   int failures = 0;

   fetch_stage #(.RESET_PC(32'h0000_0100), .DEPTH(2)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .IMEM_REQ    (IMEM_REQ),
      .IMEM_ADDR   (IMEM_ADDR),
      .IMEM_RDATA  (IMEM_RDATA),
      .REDIRECT    (REDIRECT),
      .REDIRECT_PC (REDIRECT_PC),
      .VALID_D     (VALID_D),
      .READY_D     (READY_D),
      .INSTR_D     (INSTR_D),
      .PC_D        (PC_D),
      .PCPLUS4_D   (PCPLUS4_D)
`ifdef FETCH_MISALIGN_TRAP_EN
      ,
      .MISALIGN_F  (MISALIGN_F)
`endif
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK)
      IMEM_RDATA <= IMEM_REQ ? (IMEM_ADDR ^ 32'h0000_AAAA) : 32'hDEAD_BEEF;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST = 1'b1; READY_D = 1'b1; REDIRECT = 1'b0; REDIRECT_PC = 32'h0;
      step(); step(); #1;
      chk("rst_valid", 32'(VALID_D), 32'd0);
      chk("rst_req",   32'(IMEM_REQ), 32'd0);
      chk("rst_instr", INSTR_D, 32'h0);
      chk("rst_pc",    PC_D, 32'h0);
      chk("rst_pc4",   PCPLUS4_D, 32'h4);

      // Streaming from 0x100.
      RST = 1'b0; #1;
      chk("c0_req",   32'(IMEM_REQ), 32'd1);
      chk("c0_addr",  IMEM_ADDR, 32'h100);
      chk("c0_valid", 32'(VALID_D), 32'd0);
      step(); #1;
      chk("c1_valid", 32'(VALID_D), 32'd0);
      chk("c1_addr",  IMEM_ADDR, 32'h104);
      for (int k = 0; k < 4; k++) begin
         step(); #1;
         chk("str_valid", 32'(VALID_D), 32'd1);
         chk("str_pc",    PC_D, 32'h100 + 32'(4*k));
         chk("str_instr", INSTR_D, (32'h100 + 32'(4*k)) ^ 32'h0000_AAAA);
         chk("str_pc4",   PCPLUS4_D, 32'h104 + 32'(4*k));
         chk("str_addr",  IMEM_ADDR, 32'h108 + 32'(4*k));
      end

      // Restart, then stall five cycles from the first valid.
      RST = 1'b1; step(); step(); RST = 1'b0; #1;
      chk("r2_addr", IMEM_ADDR, 32'h100);
      step(); #1;
      step(); READY_D = 1'b0; #1;
      chk("bp2_req",   32'(IMEM_REQ), 32'd0);
      chk("bp2_pc",    PC_D, 32'h100);
      for (int k = 3; k <= 6; k++) begin
         step(); #1;
         chk("bp_req",   32'(IMEM_REQ), 32'd0);
         chk("bp_valid", 32'(VALID_D), 32'd1);
         chk("bp_pc",    PC_D, 32'h100);
         chk("bp_instr", INSTR_D, 32'h0000_ABAA);
      end
      step(); READY_D = 1'b1; #1;
      chk("c7_pc",   PC_D, 32'h100);
      chk("c7_addr", IMEM_ADDR, 32'h108);
      chk("c7_req",  32'(IMEM_REQ), 32'd1);
      step(); #1;
      chk("c8_pc",   PC_D, 32'h104);
      chk("c8_addr", IMEM_ADDR, 32'h10C);

      // Redirect with 0x10C outstanding: drain cycle, target valid at t+4.
      REDIRECT = 1'b1; REDIRECT_PC = 32'h200; #1;
      step(); REDIRECT = 1'b0; #1;
      chk("rd1_valid", 32'(VALID_D), 32'd0);
      chk("rd1_req",   32'(IMEM_REQ), 32'd0);
      step(); #1;
      chk("rd2_req",   32'(IMEM_REQ), 32'd1);
      chk("rd2_addr",  IMEM_ADDR, 32'h200);
      chk("rd2_valid", 32'(VALID_D), 32'd0);
      step(); #1;
      chk("rd3_valid", 32'(VALID_D), 32'd0);
      chk("rd3_addr",  IMEM_ADDR, 32'h204);
      step(); #1;
      chk("rd4_valid", 32'(VALID_D), 32'd1);
      chk("rd4_pc",    PC_D, 32'h200);
      chk("rd4_instr", INSTR_D, 32'h0000_A8AA);

      // Fill the buffer, then redirect with nothing outstanding: valid at t+3.
      step(); READY_D = 1'b0; #1;
      chk("c13_pc",  PC_D, 32'h204);
      chk("c13_req", 32'(IMEM_REQ), 32'd0);
      step(); #1;
      chk("c14_req", 32'(IMEM_REQ), 32'd0);
      REDIRECT = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
      REDIRECT_PC = 32'h300;
`else
      REDIRECT_PC = 32'h303;
`endif
      #1;
      step(); REDIRECT = 1'b0; #1;
      chk("nd1_valid", 32'(VALID_D), 32'd0);
      chk("nd1_req",   32'(IMEM_REQ), 32'd1);
      chk("nd1_addr",  IMEM_ADDR, 32'h300);
      step(); #1;
      chk("nd2_valid", 32'(VALID_D), 32'd0);
      step(); #1;
      chk("nd3_valid", 32'(VALID_D), 32'd1);
      chk("nd3_pc",    PC_D, 32'h300);
      chk("nd3_pc4",   PCPLUS4_D, 32'h304);

      // PC wrap through 0xFFFF_FFFC.
      READY_D = 1'b1; REDIRECT = 1'b1; REDIRECT_PC = 32'hFFFF_FFF8; #1;
      step(); REDIRECT = 1'b0; #1;
      chk("wr_drain_req", 32'(IMEM_REQ), 32'd0);
      step(); #1;
      chk("wr_a0", IMEM_ADDR, 32'hFFFF_FFF8);
      step(); #1;
      chk("wr_a1", IMEM_ADDR, 32'hFFFF_FFFC);
      step(); #1;
      chk("wr_a2",  IMEM_ADDR, 32'h0000_0000);
      chk("wr_pc0", PC_D, 32'hFFFF_FFF8);
      step(); #1;
      chk("wr_pc1",  PC_D, 32'hFFFF_FFFC);
      chk("wr_pc41", PCPLUS4_D, 32'h0);
      step(); READY_D = 1'b0; #1;
      chk("wr_pc2",    PC_D, 32'h0);
      chk("wr_instr2", INSTR_D, 32'h0000_AAAA);

      // Two entries buffered, then reset.
      step(); #1;
      chk("full_req",   32'(IMEM_REQ), 32'd0);
      chk("full_valid", 32'(VALID_D), 32'd1);
      RST = 1'b1; READY_D = 1'b1; #1;
      step(); #1;
      chk("mrst_valid", 32'(VALID_D), 32'd0);
      chk("mrst_req",   32'(IMEM_REQ), 32'd0);
      chk("mrst_pc",    PC_D, 32'h0);
      RST = 1'b0; #1;
      chk("mrst_addr", IMEM_ADDR, 32'h100);
      step(); step(); #1;
      chk("mrst_first_pc", PC_D, 32'h100);
      chk("mrst_first_v",  32'(VALID_D), 32'd1);

`ifdef FETCH_MISALIGN_TRAP_EN
      REDIRECT = 1'b1; REDIRECT_PC = 32'h202; #1;
      step(); REDIRECT = 1'b0; #1;
      for (int k = 0; k < 10; k++) begin
         chk("mis_flag",  32'(MISALIGN_F), 32'd1);
         chk("mis_req",   32'(IMEM_REQ), 32'd0);
         chk("mis_valid", 32'(VALID_D), 32'd0);
         step(); #1;
      end
      REDIRECT = 1'b1; REDIRECT_PC = 32'h300; #1;
      step(); REDIRECT = 1'b0; #1;
      chk("mis_clr",  32'(MISALIGN_F), 32'd0);
      chk("mis_addr", IMEM_ADDR, 32'h300);
      step(); step(); #1;
      chk("mis_pc",    PC_D, 32'h300);
      chk("mis_valid2", 32'(VALID_D), 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
